sc_point_sequencer: RTL and testbench

- Game-level controller for the frog-point register bank; owns its control port (clear, load0=up, load1=down, 2-bit shift select).
- Arbitrates the port among four requesters: game start/respawn, player buttons, periodic lane drift (frog carried by log/car) and goal handling.
- Tracks lives and level, and flags game over.
- Sits between the button synchroniser/collision detector and the point register matrix.

---
 rtl/sc_point_sequencer_pkg.sv | 33 +++
 rtl/sc_point_sequencer_if.sv | 39 +++
 rtl/sc_point_sequencer_drifttimer.sv | 43 ++++
 rtl/sc_point_sequencer.sv | 124 ++++++++++++
 tb/tb_sc_point_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_point_sequencer_pkg.sv
// Shared types for the frog-point sequencer: state encoding,
// point-bank shift codes and lane drift directions.
package sc_point_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_PLAY,
        S_UP,
        S_DOWN,
        S_LEFT,
        S_RIGHT,
        S_DRIFT,
        S_WAIT_REL,
        S_DIE,
        S_GOAL,
        S_OVER
    } state_t;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    localparam logic [1:0] DRIFT_LEFT  = 2'b01;
    localparam logic [1:0] DRIFT_RIGHT = 2'b10;

    // Drift time only elapses while a round is actually being played.
    function automatic logic timer_run(state_t s);
        return s inside {S_PLAY, S_UP, S_DOWN, S_LEFT,
                         S_RIGHT, S_DRIFT, S_WAIT_REL};
    endfunction

endpackage

// File: rtl/sc_point_sequencer_if.sv
// Game-side bundle of the point sequencer: button/collision
// inputs toward the sequencer, point-bank commands and status back.
interface sc_point_sequencer_if;

    logic       start_InLow;
    logic       up_InLow;
    logic       down_InLow;
    logic       left_InLow;
    logic       right_InLow;
    logic       firstRow_InLow;
    logic       collision_InHigh;
    logic       goal_InHigh;
    logic [1:0] driftDir_In;

    logic       clear_OutLow;
    logic       load0_OutLow;
    logic       load1_OutLow;
    logic [1:0] shiftSel_Out;
    logic [1:0] lives_Out;
    logic [3:0] level_Out;
    logic       gameOver_OutHigh;

    modport master (
        input  start_InLow, up_InLow, down_InLow, left_InLow,
               right_InLow, firstRow_InLow, collision_InHigh,
               goal_InHigh, driftDir_In,
        output clear_OutLow, load0_OutLow, load1_OutLow,
               shiftSel_Out, lives_Out, level_Out, gameOver_OutHigh
    );

    modport slave (
        output start_InLow, up_InLow, down_InLow, left_InLow,
               right_InLow, firstRow_InLow, collision_InHigh,
               goal_InHigh, driftDir_In,
        input  clear_OutLow, load0_OutLow, load1_OutLow,
               shiftSel_Out, lives_Out, level_Out, gameOver_OutHigh
    );

endinterface

// File: rtl/sc_point_sequencer_drifttimer.sv
// Lane drift timer: free-running period counter with a one-deep
// pending flag that the sequencer consumes when it drifts the frog.
module sc_point_drifttimer
    import sc_point_pkg::*;
#(
    parameter int DRIFT_PERIOD = 25000000,
    parameter int DRIFT_W      = 25
) (
    input  logic SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic run,
    input  logic flush,
    input  logic service,
    output logic pending
);

    localparam logic [DRIFT_W-1:0] LAST = DRIFT_W'(DRIFT_PERIOD - 1);

    logic [DRIFT_W-1:0] count;
    logic               tick;

    assign tick = run && (count == LAST);

    // A tick arriving while one is still pending is dropped.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50
                or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            count   <= '0;
            pending <= 1'b0;
        end else if (flush) begin
            count   <= '0;
            pending <= 1'b0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
            if (pending) begin
                if (service) pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_point_sequencer.sv
// Frog-point game controller: arbitrates the point-bank port between
// start/respawn, buttons, lane drift and goals; tracks lives and level.
module sc_point_sequencer
    import sc_point_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int DRIFT_PERIOD = 25000000,
    parameter int DRIFT_W      = 25
) (
    input  logic SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic SC_STATEMACHINEPOINT_RESET_InHigh,
    sc_point_sequencer_if.master bus
);

    localparam logic [1:0] LIVES_LD = 2'(LIVES_INIT);

    state_t     state, state_nxt;
    logic [1:0] lives;
    logic [3:0] level;
    logic       pending;
    logic       run;
    logic       all_rel;

    assign run     = timer_run(state);
    assign all_rel = &{bus.start_InLow, bus.up_InLow, bus.down_InLow,
                       bus.left_InLow, bus.right_InLow};

    sc_point_drifttimer #(
        .DRIFT_PERIOD (DRIFT_PERIOD),
        .DRIFT_W      (DRIFT_W)
    ) u_timer (
        .SC_STATEMACHINEPOINT_CLOCK_50     (SC_STATEMACHINEPOINT_CLOCK_50),
        .SC_STATEMACHINEPOINT_RESET_InHigh (SC_STATEMACHINEPOINT_RESET_InHigh),
        .run     (run),
        .flush   (!run),
        .service (state == S_DRIFT),
        .pending (pending)
    );

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50
                or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) state <= S_IDLE;
        else                                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_OVER:
                if (!bus.start_InLow) state_nxt = S_INIT;
            S_INIT, S_UP, S_DOWN, S_LEFT, S_RIGHT, S_GOAL:
                state_nxt = S_WAIT_REL;
            S_DRIFT:
                state_nxt = S_PLAY;
            S_DIE:
                state_nxt = (lives == 2'd1) ? S_OVER : S_WAIT_REL;
            // A down press on the bottom row is swallowed outright.
            S_PLAY: begin
                if (bus.collision_InHigh)  state_nxt = S_DIE;
                else if (bus.goal_InHigh)  state_nxt = S_GOAL;
                else if (!bus.start_InLow) state_nxt = S_INIT;
                else if (!bus.up_InLow)    state_nxt = S_UP;
                else if (!bus.down_InLow) begin
                    if (bus.firstRow_InLow) state_nxt = S_DOWN;
                end
                else if (!bus.left_InLow)  state_nxt = S_LEFT;
                else if (!bus.right_InLow) state_nxt = S_RIGHT;
                else if (pending)          state_nxt = S_DRIFT;
            end
            S_WAIT_REL: begin
                if (bus.collision_InHigh) state_nxt = S_DIE;
                else if (bus.goal_InHigh) state_nxt = S_GOAL;
                else if (all_rel)         state_nxt = S_PLAY;
            end
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.clear_OutLow     = 1'b1;
        bus.load0_OutLow     = 1'b1;
        bus.load1_OutLow     = 1'b1;
        bus.shiftSel_Out     = SHIFT_HOLD;
        bus.gameOver_OutHigh = 1'b0;
        unique case (state)
            S_INIT, S_DIE, S_GOAL: bus.clear_OutLow = 1'b0;
            S_UP:                  bus.load0_OutLow = 1'b0;
            S_DOWN:                bus.load1_OutLow = 1'b0;
            S_LEFT:                bus.shiftSel_Out = SHIFT_LEFT;
            S_RIGHT:               bus.shiftSel_Out = SHIFT_RIGHT;
            S_DRIFT:
                if (bus.driftDir_In == DRIFT_LEFT ||
                    bus.driftDir_In == DRIFT_RIGHT)
                    bus.shiftSel_Out = bus.driftDir_In;
            S_OVER:                bus.gameOver_OutHigh = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50
                or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            lives <= 2'd0;
            level <= 4'd0;
        end else begin
            unique case (state)
                S_INIT: begin
                    lives <= LIVES_LD;
                    level <= 4'd0;
                end
                S_DIE:
                    if (lives != 2'd0) lives <= lives - 2'd1;
                S_GOAL:
                    if (level != 4'hF) level <= level + 4'd1;
                default: ;
            endcase
        end
    end

    assign bus.lives_Out = lives;
    assign bus.level_Out = level;

endmodule

// File: tb/tb_sc_point_sequencer.sv
// Bench for sc_point_sequencer: directed vector table, corner-case
// sequences and randomized play checked against a behavioural model.
module tb_sc_point_sequencer;

    localparam int P  = 8;
    localparam int LI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sc_point_sequencer_if bus();

    sc_point_sequencer #(
        .LIVES_INIT   (LI),
        .DRIFT_PERIOD (P),
        .DRIFT_W      (3)
    ) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic start, up, down, left, right, first_row, coll, goal;
        logic [1:0] dir;
    } in_t;

    typedef struct packed {
        logic clear, load0, load1;
        logic [1:0] shift;
        logic [1:0] lives;
        logic [3:0] level;
        logic over;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam in_t REST = 10'b11111_1_0_0_00;

    // Model: a phase of play plus a one-cycle command slot.
    typedef enum {PH_IDLE, PH_PLAY, PH_HELD, PH_OVER} phase_e;
    typedef enum {A_NONE, A_INIT, A_UP, A_DOWN, A_LEFT, A_RIGHT,
                  A_DRIFT, A_DIE, A_GOAL} act_e;

    phase_e m_phase;
    act_e   m_act;
    int     m_lives, m_level, m_cnt;
    bit     m_pend;

    function automatic out_t ox(logic c, logic l0, logic l1,
                                logic [1:0] sh, int lv, int lev,
                                logic ov);
        out_t o;
        o.clear = c; o.load0 = l0; o.load1 = l1; o.shift = sh;
        o.lives = 2'(lv); o.level = 4'(lev); o.over = ov;
        return o;
    endfunction

    function automatic out_t idle_o(int lv);
        return ox(1, 1, 1, 2'b11, lv, 0, 0);
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_act = A_NONE;
        m_lives = 0; m_level = 0; m_cnt = 0; m_pend = 0;
    endtask

    function automatic out_t model_out(logic [1:0] dir);
        out_t o;
        o = ox(1, 1, 1, 2'b11, m_lives, m_level,
               m_phase == PH_OVER && m_act == A_NONE);
        case (m_act)
            A_INIT, A_DIE, A_GOAL: o.clear = 0;
            A_UP:    o.load0 = 0;
            A_DOWN:  o.load1 = 0;
            A_LEFT:  o.shift = 2'b01;
            A_RIGHT: o.shift = 2'b10;
            A_DRIFT: o.shift = (dir == 2'b01 || dir == 2'b10) ? dir : 2'b11;
            default: ;
        endcase
        return o;
    endfunction

    task automatic model_step(input in_t x);
        bit run, p0;
        run = (m_phase == PH_PLAY || m_phase == PH_HELD) &&
              !(m_act inside {A_INIT, A_DIE, A_GOAL});
        p0 = m_pend;
        if (!run) begin
            m_cnt = 0; m_pend = 0;
        end else begin
            if (m_pend) m_pend = (m_act != A_DRIFT);
            else        m_pend = (m_cnt == P - 1);
            m_cnt = (m_cnt + 1) % P;
        end
        if (m_act != A_NONE) begin
            case (m_act)
                A_INIT: begin m_lives = LI; m_level = 0; m_phase = PH_HELD; end
                A_DRIFT: m_phase = PH_PLAY;
                A_DIE: begin
                    m_lives = m_lives - 1;
                    m_phase = (m_lives == 0) ? PH_OVER : PH_HELD;
                end
                A_GOAL: begin
                    if (m_level < 15) m_level = m_level + 1;
                    m_phase = PH_HELD;
                end
                default: m_phase = PH_HELD;
            endcase
            m_act = A_NONE;
        end else begin
            case (m_phase)
                PH_IDLE, PH_OVER: if (!x.start) m_act = A_INIT;
                PH_PLAY: begin
                    if (x.coll)        m_act = A_DIE;
                    else if (x.goal)   m_act = A_GOAL;
                    else if (!x.start) m_act = A_INIT;
                    else if (!x.up)    m_act = A_UP;
                    else if (!x.down) begin
                        if (x.first_row) m_act = A_DOWN;
                    end
                    else if (!x.left)  m_act = A_LEFT;
                    else if (!x.right) m_act = A_RIGHT;
                    else if (p0)       m_act = A_DRIFT;
                end
                default: begin
                    if (x.coll)      m_act = A_DIE;
                    else if (x.goal) m_act = A_GOAL;
                    else if (&{x.start, x.up, x.down, x.left, x.right})
                        m_phase = PH_PLAY;
                end
            endcase
        end
    endtask

    function automatic out_t read_out();
        out_t o;
        o.clear = bus.clear_OutLow; o.load0 = bus.load0_OutLow;
        o.load1 = bus.load1_OutLow; o.shift = bus.shiftSel_Out;
        o.lives = bus.lives_Out;    o.level = bus.level_Out;
        o.over  = bus.gameOver_OutHigh;
        return o;
    endfunction

    task automatic step(input in_t x, output out_t got);
        out_t exp;
        @(negedge clk);
        bus.start_InLow = x.start;  bus.up_InLow = x.up;
        bus.down_InLow = x.down;    bus.left_InLow = x.left;
        bus.right_InLow = x.right;  bus.firstRow_InLow = x.first_row;
        bus.collision_InHigh = x.coll; bus.goal_InHigh = x.goal;
        bus.driftDir_In = x.dir;
        #1;
        got = read_out();
        exp = model_out(x.dir);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model t=%0t got=%b exp=%b", $time, got, exp);
        end
        model_step(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, req);
        end
    endtask

    // Hold an event input until its clear pulse shows up.
    task automatic hit(input in_t x, input string name);
        out_t got;
        bit seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step(x, got);
            if (!got.clear) seen = 1;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        vec_t tbl[$];
        in_t  x;
        out_t got;
        int   n01, n10, nclr, last, prev;
        bit   seen;

        x = REST;
        bus.start_InLow = 1; bus.up_InLow = 1; bus.down_InLow = 1;
        bus.left_InLow = 1; bus.right_InLow = 1; bus.firstRow_InLow = 1;
        bus.collision_InHigh = 0; bus.goal_InHigh = 0; bus.driftDir_In = 0;
        model_reset();
        repeat (3) @(negedge clk);
        got = read_out();
        checks++;
        if (got !== idle_o(0)) begin
            failures++;
            $display("FAIL reset got=%b exp=%b", got, idle_o(0));
        end
        rst = 0;

        // Start, up held, down on/off the bottom row.
        tbl.push_back('{REST, idle_o(0)});
        x = REST; x.start = 0;
        tbl.push_back('{x, idle_o(0)});
        tbl.push_back('{REST, ox(0, 1, 1, 2'b11, 0, 0, 0)});
        tbl.push_back('{REST, idle_o(3)});
        tbl.push_back('{REST, idle_o(3)});
        x = REST; x.up = 0;
        tbl.push_back('{x, idle_o(3)});
        tbl.push_back('{x, ox(1, 0, 1, 2'b11, 3, 0, 0)});
        for (int i = 0; i < 4; i++) tbl.push_back('{x, idle_o(3)});
        tbl.push_back('{REST, idle_o(3)});
        x = REST; x.down = 0; x.first_row = 0;
        tbl.push_back('{x, idle_o(3)});
        tbl.push_back('{x, idle_o(3)});
        x.first_row = 1;
        tbl.push_back('{x, idle_o(3)});
        tbl.push_back('{REST, ox(1, 1, 0, 2'b11, 3, 0, 0)});
        tbl.push_back('{REST, idle_o(3)});
        foreach (tbl[k]) begin
            step(tbl[k].i, got);
            checks++;
            if (got !== tbl[k].o) begin
                failures++;
                $display("FAIL table[%0d] got=%b exp=%b", k, got, tbl[k].o);
            end
        end

        // Periodic left drift.
        x = REST; x.dir = 2'b01;
        n01 = 0; last = -100; prev = -100;
        for (int i = 0; i < 40; i++) begin
            step(x, got);
            if (got.shift == 2'b01) begin
                n01++; prev = last; last = i;
            end
        end
        check("drift_count", n01, 5);
        check("drift_gap", last - prev, P);

        // Right held across a tick; drift deferred to release.
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step(x, got);
            if (got.shift == 2'b01) seen = 1;
        end
        check("drift_sync", int'(seen), 1);
        x.right = 0; n01 = 0; n10 = 0;
        for (int i = 0; i < 12; i++) begin
            step(x, got);
            if (got.shift == 2'b01) n01++;
            if (got.shift == 2'b10) n10++;
        end
        check("right_pulses", n10, 1);
        check("drift_while_held", n01, 0);
        x.right = 1; seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(x, got);
            if (got.shift == 2'b01) seen = 1;
        end
        check("drift_after_release", int'(seen), 1);

        // Three collisions to game over, then restart.
        repeat (2) step(REST, got);
        for (int k = 0; k < 3; k++) begin
            x = REST; x.coll = 1;
            hit(x, "die_clear");
            repeat (3) step(REST, got);
            check("lives_after_die", int'(got.lives), 2 - k);
        end
        check("game_over", int'(got.over), 1);
        x = REST; x.up = 0; x.left = 0; nclr = 0;
        for (int i = 0; i < 6; i++) begin
            step(x, got);
            if (got !== ox(1, 1, 1, 2'b11, 0, 0, 1)) nclr++;
        end
        check("over_idle", nclr, 0);
        x = REST; x.start = 0;
        step(x, got);
        repeat (3) step(REST, got);
        check("restart_lives", int'(got.lives), 3);
        check("restart_over", int'(got.over), 0);

        // Collision beats goal; goal saturation.
        x = REST; x.coll = 1; x.goal = 1;
        hit(x, "coll_goal_clear");
        repeat (3) step(REST, got);
        check("coll_goal_lives", int'(got.lives), 2);
        check("coll_goal_level", int'(got.level), 0);
        x = REST; x.goal = 1;
        for (int k = 0; k < 16; k++) begin
            hit(x, "goal_clear");
            repeat (2) step(REST, got);
        end
        check("level_sat", int'(got.level), 15);

        // Reset in the middle of a LEFT command.
        x = REST; x.left = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(x, got);
            if (got.shift == 2'b01) seen = 1;
        end
        check("left_seen", int'(seen), 1);
        rst = 1;
        #1;
        got = read_out();
        checks++;
        if (got !== idle_o(0)) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", got, idle_o(0));
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        x = REST; x.left = 0; x.up = 0; nclr = 0;
        for (int i = 0; i < 10; i++) begin
            step(x, got);
            if (got !== idle_o(0)) nclr++;
        end
        check("post_reset_idle", nclr, 0);

        // Randomized play against the model.
        for (int i = 0; i < 3000; i++) begin
            x = REST;
            x.start = ($urandom_range(19) != 0);
            x.up    = ($urandom_range(5) != 0);
            x.down  = ($urandom_range(5) != 0);
            x.left  = ($urandom_range(5) != 0);
            x.right = ($urandom_range(5) != 0);
            x.first_row = 1'($urandom_range(1));
            x.coll  = ($urandom_range(39) == 0);
            x.goal  = ($urandom_range(29) == 0);
            x.dir   = 2'($urandom_range(3));
            step(x, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
